// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
//   Shares one main-memory line port between the instruction cache (refill
//   reads) and the data cache (refill reads and writebacks). Round-robin
//   arbitration with a single outstanding memory transaction. A cycle counter
//   abandons a transaction that the memory never acknowledges, so a dead
//   memory port cannot hang the core.
//
// Ports
//   i_riscv_arb_clk / i_riscv_arb_rst : clock, synchronous active-high reset
//   i_riscv_arb_ic_*  : icache request (level), line address
//   o_riscv_arb_ic_*  : icache one-cycle ack pulse and line data
//   i_riscv_arb_dc_*  : dcache request (level), wr (1=writeback), addr, wdata
//   o_riscv_arb_dc_*  : dcache one-cycle ack pulse and line data
//   o_riscv_arb_mem_* : memory request (held until ack), wr, addr, wdata
//   i_riscv_arb_mem_* : memory one-cycle ack pulse and read data
//   o_riscv_arb_timeout : sticky flag, set when a transaction timed out
// All outputs are registered.
// ---------------------------------------------------------------------------
module riscv_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              i_riscv_arb_clk,
    input  logic              i_riscv_arb_rst,
    input  logic              i_riscv_arb_ic_req,
    input  logic [ADDR_W-1:0] i_riscv_arb_ic_addr,
    output logic              o_riscv_arb_ic_ack,
    output logic [LINE_W-1:0] o_riscv_arb_ic_rdata,
    input  logic              i_riscv_arb_dc_req,
    input  logic              i_riscv_arb_dc_wr,
    input  logic [ADDR_W-1:0] i_riscv_arb_dc_addr,
    input  logic [LINE_W-1:0] i_riscv_arb_dc_wdata,
    output logic              o_riscv_arb_dc_ack,
    output logic [LINE_W-1:0] o_riscv_arb_dc_rdata,
    output logic              o_riscv_arb_mem_req,
    output logic              o_riscv_arb_mem_wr,
    output logic [ADDR_W-1:0] o_riscv_arb_mem_addr,
    output logic [LINE_W-1:0] o_riscv_arb_mem_wdata,
    input  logic              i_riscv_arb_mem_ack,
    input  logic [LINE_W-1:0] i_riscv_arb_mem_rdata,
    output logic              o_riscv_arb_timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state_reg, state_next;
    logic                last_dc_reg, last_dc_next;   // 1 = DC had the last grant
    logic                gnt_dc_reg, gnt_dc_next;     // owner of the current transaction
    logic [7:0]          cnt_reg, cnt_next;
    logic                mem_req_reg, mem_req_next;
    logic                mem_wr_reg, mem_wr_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [LINE_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic                ic_ack_reg, ic_ack_next;
    logic [LINE_W-1:0]   ic_rdata_reg, ic_rdata_next;
    logic                dc_ack_reg, dc_ack_next;
    logic [LINE_W-1:0]   dc_rdata_reg, dc_rdata_next;
    logic                timeout_reg, timeout_next;

    logic                pick_dc;
    logic                finish;
    logic [LINE_W-1:0]   cap_rdata;

    always_comb begin
        state_next     = state_reg;
        last_dc_next   = last_dc_reg;
        gnt_dc_next    = gnt_dc_reg;
        cnt_next       = cnt_reg;
        mem_req_next   = mem_req_reg;
        mem_wr_next    = mem_wr_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        ic_ack_next    = 1'b0;
        ic_rdata_next  = ic_rdata_reg;
        dc_ack_next    = 1'b0;
        dc_rdata_next  = dc_rdata_reg;
        timeout_next   = timeout_reg;
        pick_dc        = 1'b0;
        finish         = 1'b0;
        cap_rdata      = '0;

        case (state_reg)
            IDLE: begin
                if (i_riscv_arb_ic_req || i_riscv_arb_dc_req) begin
                    // On a tie the requester that did not win last time goes first.
                    pick_dc        = i_riscv_arb_dc_req && (!i_riscv_arb_ic_req || !last_dc_reg);
                    gnt_dc_next    = pick_dc;
                    last_dc_next   = pick_dc;
                    cnt_next       = '0;
                    mem_req_next   = 1'b1;
                    mem_wr_next    = pick_dc && i_riscv_arb_dc_wr;
                    mem_addr_next  = pick_dc ? i_riscv_arb_dc_addr : i_riscv_arb_ic_addr;
                    mem_wdata_next = pick_dc ? i_riscv_arb_dc_wdata : '0;
                    state_next     = BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 8'd1;
                if (i_riscv_arb_mem_ack) begin
                    finish    = 1'b1;
                    // A writeback returns no data.
                    cap_rdata = mem_wr_reg ? '0 : i_riscv_arb_mem_rdata;
                end else if (cnt_next == TIMEOUT_CNT) begin
                    // Memory never answered: complete the requester with zero data.
                    finish       = 1'b1;
                    timeout_next = 1'b1;
                end
                if (finish) begin
                    mem_req_next = 1'b0;
                    mem_wr_next  = 1'b0;
                    state_next   = RESP;
                    if (gnt_dc_reg) begin
                        dc_ack_next   = 1'b1;
                        dc_rdata_next = cap_rdata;
                    end else begin
                        ic_ack_next   = 1'b1;
                        ic_rdata_next = cap_rdata;
                    end
                end
            end
            // Ack pulse is visible during RESP; GAP gives the requester time
            // to drop its request before IDLE samples again.
            RESP:    state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_arb_clk) begin
        if (i_riscv_arb_rst) begin
            state_reg     <= IDLE;
            last_dc_reg   <= 1'b0;
            gnt_dc_reg    <= 1'b0;
            cnt_reg       <= '0;
            mem_req_reg   <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            ic_ack_reg    <= 1'b0;
            ic_rdata_reg  <= '0;
            dc_ack_reg    <= 1'b0;
            dc_rdata_reg  <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_dc_reg   <= last_dc_next;
            gnt_dc_reg    <= gnt_dc_next;
            cnt_reg       <= cnt_next;
            mem_req_reg   <= mem_req_next;
            mem_wr_reg    <= mem_wr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            ic_ack_reg    <= ic_ack_next;
            ic_rdata_reg  <= ic_rdata_next;
            dc_ack_reg    <= dc_ack_next;
            dc_rdata_reg  <= dc_rdata_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign o_riscv_arb_ic_ack    = ic_ack_reg;
    assign o_riscv_arb_ic_rdata  = ic_rdata_reg;
    assign o_riscv_arb_dc_ack    = dc_ack_reg;
    assign o_riscv_arb_dc_rdata  = dc_rdata_reg;
    assign o_riscv_arb_mem_req   = mem_req_reg;
    assign o_riscv_arb_mem_wr    = mem_wr_reg;
    assign o_riscv_arb_mem_addr  = mem_addr_reg;
    assign o_riscv_arb_mem_wdata = mem_wdata_reg;
    assign o_riscv_arb_timeout   = timeout_reg;

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one main-memory line port between the instruction cache (refill reads) and the data cache (refill reads, writebacks).
- Sits between the two caches and the external memory model, below the core.
- Round-robin arbitration; one outstanding memory transaction at a time.
- A timeout counter keeps a dead memory port from hanging the core.

Parameters:
ADDR_W, 64, address width of all address ports
LINE_W, 128, cache line width in bits (data ports)
TIMEOUT, 255, max cycles o_riscv_arb_mem_req may stay high without ack (8-bit counter; legal range 1..255)

Ports:
i_riscv_arb_clk  in  1  clock
i_riscv_arb_rst  in  1  synchronous active-high reset
i_riscv_arb_ic_req  in  1  icache read request (level)
i_riscv_arb_ic_addr  in  ADDR_W  icache line address
o_riscv_arb_ic_ack  out  1  one-cycle completion pulse to icache
o_riscv_arb_ic_rdata  out  LINE_W  icache line data, valid with ack
i_riscv_arb_dc_req  in  1  dcache request (level)
i_riscv_arb_dc_wr  in  1  1=writeback, 0=refill read
i_riscv_arb_dc_addr  in  ADDR_W  dcache line address
i_riscv_arb_dc_wdata  in  LINE_W  writeback line
o_riscv_arb_dc_ack  out  1  one-cycle completion pulse to dcache
o_riscv_arb_dc_rdata  out  LINE_W  dcache line data, valid with ack
o_riscv_arb_mem_req  out  1  memory request, held until ack
o_riscv_arb_mem_wr  out  1  memory write enable
o_riscv_arb_mem_addr  out  ADDR_W  memory address
o_riscv_arb_mem_wdata  out  LINE_W  memory write data
i_riscv_arb_mem_ack  in  1  one-cycle memory completion pulse
i_riscv_arb_mem_rdata  in  LINE_W  memory read data, valid with mem_ack
o_riscv_arb_timeout  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock i_riscv_arb_clk; reset i_riscv_arb_rst is synchronous, active-high.
- Registered outputs: all outputs are registered.
- Reset values: every output is 0; state=IDLE; last_grant=IC, so DC wins the first tie; timeout counter=0.
- FSM states: IDLE, BUSY, RESP, GAP.
- IDLE, no request: stay in IDLE.
- IDLE, one requester: grant it.
- IDLE, both requesters: grant the one that is not last_grant.
- On grant: latch addr, wr (forced 0 for IC) and wdata (0 for IC) into the mem_* outputs; set mem_req=1; update last_grant; go to BUSY.
- Request latency: request sampled in IDLE at cycle 0 gives mem_req=1 from cycle 1.
- BUSY: mem_req and mem_* held stable. Counter increments each cycle.
- BUSY, mem_ack=1: capture mem_rdata (zero it if wr=1); clear mem_req and mem_wr; go to RESP.
- BUSY, counter reaches TIMEOUT without ack: clear mem_req; set o_riscv_arb_timeout=1; capture rdata=0; go to RESP.
- mem_ack outside BUSY is ignored.
- RESP: ack=1 to the granted requester only, rdata driven for this one cycle; go to GAP.
- Completion latency: mem_ack at cycle k gives requester ack at k+1.
- GAP: one dead cycle, requests not sampled; go to IDLE.
- Requester rule: a requester must deassert req in the cycle after its ack, and before IDLE samples again.
- Minimum turnaround: mem_ack at cycle k; earliest next grant sampled at k+3; next mem_req at k+4.
- Request changes while not IDLE: ignored; the latched transaction is unaffected.
- rdata hold: o_riscv_arb_*_rdata holds its last value outside ack. Only the ack cycle is meaningful.
- o_riscv_arb_timeout: sticky until reset.
- Reset mid-transaction: next edge returns everything to reset values; mem_req drops. The abandoned memory transaction is not completed, and no ack is issued to the requester.

Test Plan:
- Single IC read:
  - Stimulus: ic_req=1, addr=0x1000; memory acks 3 cycles after mem_req with rdata=0xA5A5...A5.
  - Response: mem_req high from cycle 1 to cycle 3; mem_wr=0; mem_addr=0x1000; ic_ack pulses at cycle 4 with that data; dc_ack stays 0.
- DC writeback:
  - Stimulus: dc_req=1, wr=1, addr=0x2040, wdata=0x0123...EF; memory acks after 2 cycles.
  - Response: mem_wr=1 and mem_wdata=wdata while mem_req is high; dc_ack pulses once with dc_rdata=0.
- Simultaneous requests after reset:
  - Stimulus: ic_req and dc_req both high at cycle 0; both re-request after their acks.
  - Response: grants go DC, then IC, then DC (round robin); each ack goes only to the granted requester; consecutive mem_req pulses are separated by the GAP turnaround.
- Timeout:
  - Stimulus: TIMEOUT=4; IC request; memory never acks.
  - Response: mem_req drops after 4 BUSY cycles; ic_ack pulses with rdata=0; o_riscv_arb_timeout=1 and stays 1; a later normal transaction still completes.
- Reset mid-BUSY:
  - Stimulus: assert rst for 1 cycle during DC BUSY.
  - Response: next cycle has mem_req=0, timeout=0, no dc_ack; a following ic_req+dc_req tie is granted to DC.
- Spurious ack:
  - Stimulus: mem_ack pulses while in IDLE with no requests.
  - Response: no ack output; state stays IDLE.
